// File: rtl/tl45_pkg.sv
// rtl/tl45_pkg.sv - shared types and constants for the TL45 multiply/divide unit
package tl45_pkg;

   localparam int TL45_REG_ADDR_W = 4;

   typedef enum logic [2:0] {
      OP_MUL   = 3'd0,
      OP_MULH  = 3'd1,
      OP_MULHU = 3'd2,
      OP_DIV   = 3'd3,
      OP_UDIV  = 3'd4,
      OP_REM   = 3'd5,
      OP_REMU  = 3'd6,
      OP_RSVD  = 3'd7
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } muldiv_state_e;

endpackage

// File: rtl/tl45_muldiv_if.sv
// rtl/tl45_muldiv_if.sv - request/result bundle between the execute stage and the muldiv unit
interface tl45_muldiv_if #(
   parameter int WIDTH      = 32,
   parameter int REG_ADDR_W = tl45_pkg::TL45_REG_ADDR_W
);
   logic                  i_flush;
   logic                  i_valid;
   logic                  o_ready;
   logic [2:0]            i_op;
   logic [REG_ADDR_W-1:0] i_dr;
   logic [WIDTH-1:0]      i_a;
   logic [WIDTH-1:0]      i_b;
   logic                  o_valid;
   logic [REG_ADDR_W-1:0] o_dr;
   logic [WIDTH-1:0]      o_value;
   logic                  o_busy;
   logic                  o_div_zero;

   modport master (
      output i_flush, i_valid, i_op, i_dr, i_a, i_b,
      input  o_ready, o_valid, o_dr, o_value, o_busy, o_div_zero
   );

   modport slave (
      input  i_flush, i_valid, i_op, i_dr, i_a, i_b,
      output o_ready, o_valid, o_dr, o_value, o_busy, o_div_zero
   );
endinterface

// File: rtl/tl45_divu_core.sv
// rtl/tl45_divu_core.sv - unsigned iterative restoring divider, one quotient bit per cycle
module tl45_divu_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             abort_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             done_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   logic             busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
   logic [WIDTH:0]   rem_sh, diff;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         quo_q  <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         dvs_q  <= dvs_d;
      end
   end

   // The quotient register doubles as the dividend shift register.
   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      quo_d  = quo_q;
      rem_d  = rem_q;
      dvs_d  = dvs_q;
      rem_sh = {rem_q, quo_q[WIDTH-1]};
      diff   = rem_sh - {1'b0, dvs_q};
      if (abort_i) begin
         busy_d = 1'b0;
         cnt_d  = '0;
      end else if (start_i) begin
         busy_d = 1'b1;
         cnt_d  = '0;
         quo_d  = dividend_i;
         rem_d  = '0;
         dvs_d  = divisor_i;
      end else if (busy_q) begin
         if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_d = rem_sh[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
         end
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LAST) begin
            busy_d = 1'b0;
            cnt_d  = '0;
         end
      end
   end

   assign done_o      = busy_q && (cnt_q == LAST);
   assign quotient_o  = quo_q;
   assign remainder_o = rem_q;
endmodule

// File: rtl/tl45_muldiv.sv
// rtl/tl45_muldiv.sv - TL45 execute-stage multi-cycle multiply/divide unit with flush and stall
module tl45_muldiv
   import tl45_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MUL_LATENCY = 5,
   parameter int REG_ADDR_W  = TL45_REG_ADDR_W
) (
   input logic          i_clk,
   input logic          i_reset_n,
   tl45_muldiv_if.slave bus
);
   localparam int MC_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   muldiv_state_e         state_q, state_d;
   logic [MC_W-1:0]       mcnt_q, mcnt_d;
   muldiv_op_e            op_q, op_d;
   logic [REG_ADDR_W-1:0] dr_q, dr_d, rdr_q, rdr_d;
   logic [WIDTH-1:0]      a_q, a_d, b_q, b_d, value_q, value_d;
   logic                  neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
   logic                  valid_q, valid_d, dz_q, dz_d;

   logic                  accept, is_mul_in, is_sdiv_in, is_rem_in, mul_signed;
   muldiv_op_e            op_in, mul_op;
   logic [WIDTH-1:0]      mul_a, mul_b, mul_res, abs_a, abs_b, quo, rem;
   logic [2*WIDTH-1:0]    ext_a, ext_b, product;
   logic                  div_start, div_done;

   assign accept     = bus.i_valid && (state_q == ST_IDLE) && !bus.i_flush;
   assign op_in      = muldiv_op_e'(bus.i_op);
   assign is_mul_in  = op_in inside {OP_MUL, OP_MULH, OP_MULHU};
   assign is_sdiv_in = op_in inside {OP_DIV, OP_REM};
   assign is_rem_in  = op_in inside {OP_REM, OP_REMU};

   // Multiplier sees live operands on the accept cycle so a latency of 1 needs no MUL state.
   assign mul_op     = (state_q == ST_IDLE) ? op_in : op_q;
   assign mul_a      = (state_q == ST_IDLE) ? bus.i_a : a_q;
   assign mul_b      = (state_q == ST_IDLE) ? bus.i_b : b_q;
   assign mul_signed = (mul_op != OP_MULHU);
   assign ext_a      = mul_signed ? {{WIDTH{mul_a[WIDTH-1]}}, mul_a} : {{WIDTH{1'b0}}, mul_a};
   assign ext_b      = mul_signed ? {{WIDTH{mul_b[WIDTH-1]}}, mul_b} : {{WIDTH{1'b0}}, mul_b};
   assign product    = ext_a * ext_b;
   assign mul_res    = (mul_op == OP_MUL) ? product[WIDTH-1:0] : product[2*WIDTH-1:WIDTH];

   assign abs_a = (is_sdiv_in && bus.i_a[WIDTH-1]) ? -bus.i_a : bus.i_a;
   assign abs_b = (is_sdiv_in && bus.i_b[WIDTH-1]) ? -bus.i_b : bus.i_b;

   tl45_divu_core #(.WIDTH(WIDTH)) u_divu (
      .clk_i       (i_clk),
      .rst_ni      (i_reset_n),
      .abort_i     (bus.i_flush),
      .start_i     (div_start),
      .dividend_i  (abs_a),
      .divisor_i   (abs_b),
      .done_o      (div_done),
      .quotient_o  (quo),
      .remainder_o (rem)
   );

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q   <= ST_IDLE;
         mcnt_q    <= '0;
         op_q      <= OP_MUL;
         dr_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         valid_q   <= 1'b0;
         rdr_q     <= '0;
         value_q   <= '0;
         dz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcnt_q    <= mcnt_d;
         op_q      <= op_d;
         dr_q      <= dr_d;
         a_q       <= a_d;
         b_q       <= b_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         valid_q   <= valid_d;
         rdr_q     <= rdr_d;
         value_q   <= value_d;
         dz_q      <= dz_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mcnt_d    = mcnt_q;
      op_d      = op_q;
      dr_d      = dr_q;
      a_d       = a_q;
      b_d       = b_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      valid_d   = 1'b0;
      rdr_d     = '0;
      value_d   = '0;
      dz_d      = 1'b0;
      div_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_d      = op_in;
               dr_d      = bus.i_dr;
               a_d       = bus.i_a;
               b_d       = bus.i_b;
               neg_quo_d = is_sdiv_in && (bus.i_a[WIDTH-1] ^ bus.i_b[WIDTH-1]);
               neg_rem_d = is_sdiv_in && bus.i_a[WIDTH-1];
               if (is_mul_in) begin
                  if (MUL_LATENCY == 1) begin
                     valid_d = 1'b1;
                     rdr_d   = bus.i_dr;
                     value_d = mul_res;
                  end else begin
                     state_d = ST_MUL;
                     mcnt_d  = MC_W'(MUL_LATENCY - 1);
                  end
               end else if (op_in == OP_RSVD) begin
                  valid_d = 1'b1;
               end else if (bus.i_b == '0) begin
                  valid_d = 1'b1;
                  rdr_d   = bus.i_dr;
                  value_d = is_rem_in ? bus.i_a : '1;
                  dz_d    = 1'b1;
               end else if (is_sdiv_in && bus.i_a == MOST_NEG && bus.i_b == '1) begin
                  valid_d = 1'b1;
                  rdr_d   = bus.i_dr;
                  value_d = is_rem_in ? '0 : MOST_NEG;
               end else begin
                  div_start = 1'b1;
                  state_d   = ST_DIV;
               end
            end
         end
         ST_MUL: begin
            mcnt_d = mcnt_q - 1'b1;
            if (mcnt_d == '0) begin
               valid_d = 1'b1;
               rdr_d   = dr_q;
               value_d = mul_res;
               state_d = ST_IDLE;
            end
         end
         ST_DIV: begin
            if (div_done) state_d = ST_FIX;
         end
         ST_FIX: begin
            valid_d = 1'b1;
            rdr_d   = dr_q;
            if (op_q inside {OP_REM, OP_REMU}) value_d = neg_rem_q ? -rem : rem;
            else                               value_d = neg_quo_q ? -quo : quo;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (bus.i_flush) begin
         state_d   = ST_IDLE;
         mcnt_d    = '0;
         valid_d   = 1'b0;
         rdr_d     = '0;
         value_d   = '0;
         dz_d      = 1'b0;
         div_start = 1'b0;
      end
   end

   always_comb begin
      bus.o_ready    = (state_q == ST_IDLE);
      bus.o_busy     = (bus.i_valid && !accept) || (state_q != ST_IDLE);
      bus.o_valid    = valid_q;
      bus.o_dr       = rdr_q;
      bus.o_value    = value_q;
      bus.o_div_zero = dz_q;
   end
endmodule

// File: tb/tb_tl45_muldiv.sv
// tb/tb_tl45_muldiv.sv - self-checking bench for tl45_muldiv against an arithmetic reference model
module tb_tl45_muldiv;
   localparam int W   = 32;
   localparam int LAT = 5;
   localparam int RA  = 4;
   localparam logic [31:0] MINV = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   n_valid;

   always #5 clk = ~clk;

   tl45_muldiv_if #(.WIDTH(W), .REG_ADDR_W(RA)) bus ();

   tl45_muldiv #(.WIDTH(W), .MUL_LATENCY(LAT), .REG_ADDR_W(RA)) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model(input int op, input logic [3:0] dr, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] val,
                                 output logic [3:0] edr, output logic dz, output int lat);
      longint sa, sb;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      val = '0; edr = dr; dz = 1'b0; lat = W + 2; p = '0;
      if (op <= 1) begin
         p = 64'(sa * sb); val = (op == 0) ? p[31:0] : p[63:32]; lat = LAT;
      end else if (op == 2) begin
         p = {32'd0, a} * {32'd0, b}; val = p[63:32]; lat = LAT;
      end else if (op == 7) begin
         edr = '0; lat = 1;
      end else if (b == 32'd0) begin
         dz = 1'b1; lat = 1; val = (op == 5 || op == 6) ? a : 32'hFFFF_FFFF;
      end else if ((op == 3 || op == 5) && a == MINV && b == 32'hFFFF_FFFF) begin
         lat = 1; val = (op == 3) ? MINV : 32'd0;
      end else if (op == 3) val = 32'(sa / sb);
      else if (op == 5) val = 32'(sa % sb);
      else if (op == 4) val = a / b;
      else val = a % b;
   endfunction

   // Called at a falling edge with the unit idle; returns at the falling edge of the result cycle.
   task automatic do_op(input int op, input logic [3:0] dr, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
      logic [31:0] ev;
      logic [3:0]  edr;
      logic        dz;
      int          lat;
      int          seen;
      model(op, dr, a, b, ev, edr, dz, lat);
      chk({tag, " ready"}, 64'(bus.o_ready), 64'(1));
      bus.i_valid = 1'b1; bus.i_op = 3'(op); bus.i_dr = dr; bus.i_a = a; bus.i_b = b;
      @(posedge clk); #1;
      bus.i_op = 3'($urandom); bus.i_dr = 4'($urandom); bus.i_a = $urandom; bus.i_b = $urandom;
      seen = 0;
      for (int k = 1; k <= 60 && seen == 0; k++) begin
         @(negedge clk);
         if (k == 1) chk({tag, " ready c1"}, 64'(bus.o_ready), 64'(lat == 1));
         if (bus.o_valid) seen = k;
      end
      bus.i_valid = 1'b0;
      chk({tag, " latency"}, 64'(seen), 64'(lat));
      chk({tag, " dr"}, 64'(bus.o_dr), 64'(edr));
      chk({tag, " value"}, 64'(bus.o_value), 64'(ev));
      chk({tag, " div_zero"}, 64'(bus.o_div_zero), 64'(dz));
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return MINV;
         3:       return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      bus.i_flush = 1'b0; bus.i_valid = 1'b0; bus.i_op = '0;
      bus.i_dr = '0; bus.i_a = '0; bus.i_b = '0;
      repeat (2) @(negedge clk);
      chk("rst o_valid", 64'(bus.o_valid), 64'(0));
      chk("rst o_ready", 64'(bus.o_ready), 64'(1));
      chk("rst o_busy", 64'(bus.o_busy), 64'(0));
      chk("rst o_dr", 64'(bus.o_dr), 64'(0));
      chk("rst o_value", 64'(bus.o_value), 64'(0));
      chk("rst o_div_zero", 64'(bus.o_div_zero), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);

      do_op(0, 4'd2, 32'd7, 32'hFFFF_FFFD, "mul");
      do_op(1, 4'd3, 32'd7, 32'hFFFF_FFFD, "mulh");
      do_op(2, 4'd4, 32'hFFFF_FFFF, 32'd2, "mulhu");
      do_op(3, 4'd5, 32'hFFFF_FFF9, 32'd2, "div");
      do_op(5, 4'd6, 32'hFFFF_FFF9, 32'd2, "rem");
      do_op(4, 4'd7, 32'd100, 32'd7, "udiv");
      do_op(6, 4'd8, 32'd100, 32'd7, "remu");
      do_op(4, 4'd9, 32'd5, 32'd0, "udiv0");
      do_op(6, 4'd10, 32'd5, 32'd0, "remu0");
      do_op(3, 4'd11, MINV, 32'hFFFF_FFFF, "divovf");
      do_op(5, 4'd12, MINV, 32'hFFFF_FFFF, "removf");
      do_op(7, 4'd13, 32'd1, 32'd2, "rsvd");
      do_op(0, 4'd1, 32'd6, 32'd9, "b2b first");
      do_op(0, 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "b2b second");
      @(negedge clk);
      chk("pulse drop valid", 64'(bus.o_valid), 64'(0));
      chk("pulse drop value", 64'(bus.o_value), 64'(0));

      // Flush a divide in cycle 10, then multiply from cycle 11.
      bus.i_valid = 1'b1; bus.i_op = 3'd3; bus.i_dr = 4'd1; bus.i_a = 32'd1000; bus.i_b = 32'd3;
      @(posedge clk); #1 bus.i_valid = 1'b0;
      n_valid = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (bus.o_valid) n_valid++;
         if (k == 10) bus.i_flush = 1'b1;
      end
      @(posedge clk); #1 bus.i_flush = 1'b0;
      @(negedge clk);
      chk("flush ready c11", 64'(bus.o_ready), 64'(1));
      do_op(0, 4'd5, 32'd3, 32'd4, "mul after flush");
      repeat (30) begin
         @(negedge clk);
         if (bus.o_valid) n_valid++;
      end
      chk("flush no valid", 64'(n_valid), 64'(0));

      // A request presented with flush is not accepted.
      bus.i_valid = 1'b1; bus.i_flush = 1'b1; bus.i_op = 3'd4; bus.i_a = 32'd9; bus.i_b = 32'd3;
      #1 chk("flush req busy", 64'(bus.o_busy), 64'(1));
      @(posedge clk); #1 bus.i_valid = 1'b0; bus.i_flush = 1'b0;
      chk("flush req ready", 64'(bus.o_ready), 64'(1));
      n_valid = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.o_valid) n_valid++;
      end
      chk("flush req no valid", 64'(n_valid), 64'(0));

      // Reset mid-multiply.
      bus.i_valid = 1'b1; bus.i_op = 3'd0; bus.i_dr = 4'd3; bus.i_a = 32'd123; bus.i_b = 32'd456;
      @(posedge clk); #1 bus.i_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst mid ready", 64'(bus.o_ready), 64'(1));
      chk("rst mid busy", 64'(bus.o_busy), 64'(0));
      n_valid = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.o_valid) n_valid++;
      end
      rst_n = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (bus.o_valid) n_valid++;
      end
      chk("rst mid no valid", 64'(n_valid), 64'(0));

      // Reset clears a visible result at once.
      do_op(0, 4'd7, 32'd11, 32'd13, "pre reset");
      rst_n = 1'b0;
      #1;
      chk("rst clr valid", 64'(bus.o_valid), 64'(0));
      chk("rst clr value", 64'(bus.o_value), 64'(0));
      chk("rst clr dr", 64'(bus.o_dr), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 40; i++) begin
         do_op(int'($urandom_range(0, 7)), 4'($urandom), pick(), pick(), $sformatf("rand%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
